// File: rtl/nn_ram_model_p.sv
// nn_ram_model_p: parametrised single-port behavioural RAM model for the NN core benches.
// Replaces the fixed data/weight/instruction RAM models with one block.
// Reads are read-first and go through a READ_LATENCY-deep {valid, data} pipeline.
// An access to a word index >= DEPTH raises a sticky err_oob flag.
// Optional feature macro: NN_RAM_STATS_EN builds saturating accept/write counters.
module nn_ram_model_p #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int BYTE_ADDR    = 1
) (
    input  logic                  i_clka,
    input  logic                  i_rsta,
    input  logic                  i_ena,
    input  logic [DATA_W/8-1:0]   i_wea,
    input  logic [ADDR_W-1:0]     i_addra,
    input  logic [DATA_W-1:0]     i_dina,
    output logic [DATA_W-1:0]     o_douta,
    output logic                  o_rd_valid,
    output logic                  o_err_oob,
    output logic [31:0]           o_rd_count,
    output logic [31:0]           o_wr_count
);

    localparam int NB    = DATA_W / 8;
    localparam int SHIFT = (NB > 1) ? $clog2(NB) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Parameter sanity checks, reported at elaboration
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_badLatency
        $error("nn_ram_model_p: READ_LATENCY must be in 1..4");
    end
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_badDataW
        $error("nn_ram_model_p: DATA_W must be a non-zero multiple of 8");
    end
    if (ADDR_W < IDX_W) begin : g_badAddrW
        $error("nn_ram_model_p: ADDR_W too narrow to index DEPTH words");
    end

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_pipeValid;
    logic [DATA_W-1:0]       r_pipeData [READ_LATENCY];
    logic                    r_errOob;

    logic [ADDR_W-1:0] w_idx;
    logic [IDX_W-1:0]  w_memIdx;
    logic              w_accept;
    logic              w_oob;
    logic              w_anyWrite;
    logic [DATA_W-1:0] w_rdData;

    // Word index from the address; in byte mode the sub-word bits are simply dropped
    assign w_idx      = (BYTE_ADDR != 0) ? (i_addra >> SHIFT) : i_addra;
    assign w_memIdx   = w_idx[IDX_W-1:0];
    assign w_oob      = (64'(w_idx) >= 64'(DEPTH));
    assign w_accept   = i_ena && !i_rsta;
    assign w_anyWrite = (i_wea != '0);
    assign w_rdData   = w_oob ? '0 : r_mem[w_memIdx];

    // Byte-masked write; contents survive reset and out-of-range writes are dropped
    always_ff @(posedge i_clka) begin
        if (w_accept && !w_oob) begin
            for (int b = 0; b < NB; b++) begin
                if (i_wea[b]) begin
                    r_mem[w_memIdx][8*b +: 8] <= i_dina[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures the pre-write word, data only moves with a valid bit
    always_ff @(posedge i_clka) begin
        if (i_rsta) begin
            r_pipeValid <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_pipeData[s] <= '0;
            end
        end else begin
            r_pipeValid[0] <= w_accept;
            if (w_accept) begin
                r_pipeData[0] <= w_rdData;
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipeValid[s] <= r_pipeValid[s-1];
                if (r_pipeValid[s-1]) begin
                    r_pipeData[s] <= r_pipeData[s-1];
                end
            end
        end
    end

    // Sticky out-of-range flag, cleared only by reset
    always_ff @(posedge i_clka) begin
        if (i_rsta) begin
            r_errOob <= 1'b0;
        end else if (w_accept && w_oob) begin
            r_errOob <= 1'b1;
        end
    end

    assign o_douta    = r_pipeData[READ_LATENCY-1];
    assign o_rd_valid = r_pipeValid[READ_LATENCY-1];
    assign o_err_oob  = r_errOob;

`ifdef NN_RAM_STATS_EN
    logic [31:0] r_rdCount;
    logic [31:0] r_wrCount;

    // Saturating counters of accepted cycles and of accepted cycles carrying a write
    always_ff @(posedge i_clka) begin
        if (i_rsta) begin
            r_rdCount <= '0;
            r_wrCount <= '0;
        end else if (w_accept) begin
            if (r_rdCount != 32'hFFFF_FFFF) begin
                r_rdCount <= r_rdCount + 32'd1;
            end
            if (w_anyWrite && (r_wrCount != 32'hFFFF_FFFF)) begin
                r_wrCount <= r_wrCount + 32'd1;
            end
        end
    end

    assign o_rd_count = r_rdCount;
    assign o_wr_count = r_wrCount;
`else
    logic w_unusedStats;

    assign w_unusedStats = w_anyWrite;
    assign o_rd_count    = '0;
    assign o_wr_count    = '0;
`endif

endmodule

// File: tb/tb_nn_ram_model_p.sv
// tb_nn_ram_model_p: directed bench for nn_ram_model_p (32-bit, 1024 words, byte addressed, latency 3).
// A queue-based reference model predicts every output each cycle; literal checks pin key results.
module tb_nn_ram_model_p;

    localparam int LAT   = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rsta;
    logic        ena;
    logic [3:0]  wea;
    logic [31:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic        rdValid;
    logic        errOob;
    logic [31:0] rdCount;
    logic [31:0] wrCount;

    int assertCount = 0;
    int failCount   = 0;
    bit modelReady  = 1'b0;

    nn_ram_model_p #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .READ_LATENCY(LAT), .BYTE_ADDR(1)
    ) dut (
        .i_clka(clk), .i_rsta(rsta), .i_ena(ena), .i_wea(wea), .i_addra(addra),
        .i_dina(dina), .o_douta(douta), .o_rd_valid(rdValid), .o_err_oob(errOob),
        .o_rd_count(rdCount), .o_wr_count(wrCount)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Reference model state: word contents with per-byte knowledge, and pending read results
    typedef struct {
        longint      due;
        logic [31:0] data;
        bit          known;
    } rdEntry_t;

    logic [31:0] modelMem   [int];
    logic [3:0]  modelKnown [int];
    rdEntry_t    rdQueue [$];
    longint      cycleNum = 0;
    bit          expValid = 1'b0;
    logic [31:0] expDouta = '0;
    bit          expKnown = 1'b1;
    bit          expOob   = 1'b0;
    logic [31:0] expRd    = '0;
    logic [31:0] expWr    = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and return on the next falling edge
    task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] we,
                                 input logic [31:0] addr, input logic [31:0] din);
        rsta  = rst;
        ena   = en;
        wea   = we;
        addra = addr;
        dina  = din;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
    endtask

    // Reference model: applies the RAM rules to the inputs seen at each rising edge
    always @(posedge clk) begin
        int          idx;
        bit          oob;
        rdEntry_t    ent;
        cycleNum++;
        if (rsta) begin
            rdQueue.delete();
            expValid = 1'b0;
            expDouta = '0;
            expKnown = 1'b1;
            expOob   = 1'b0;
            expRd    = '0;
            expWr    = '0;
        end else begin
            if (ena) begin
                idx = int'(addra / 4);
                oob = (addra / 4) >= DEPTH;
                ent.due = cycleNum + LAT - 1;
                if (oob) begin
                    ent.data  = '0;
                    ent.known = 1'b1;
                    expOob    = 1'b1;
                end else begin
                    ent.data  = modelMem.exists(idx) ? modelMem[idx] : '0;
                    ent.known = modelKnown.exists(idx) && (modelKnown[idx] == 4'hF);
                    if (wea != 4'h0) begin
                        if (!modelMem.exists(idx)) begin
                            modelMem[idx]   = '0;
                            modelKnown[idx] = 4'h0;
                        end
                        for (int b = 0; b < 4; b++) begin
                            if (wea[b]) begin
                                modelMem[idx][8*b +: 8] = dina[8*b +: 8];
                                modelKnown[idx][b]      = 1'b1;
                            end
                        end
                    end
                end
                rdQueue.push_back(ent);
                if (expRd != 32'hFFFF_FFFF) expRd = expRd + 1;
                if ((wea != 4'h0) && (expWr != 32'hFFFF_FFFF)) expWr = expWr + 1;
            end
            expValid = 1'b0;
            if (rdQueue.size() > 0 && rdQueue[0].due == cycleNum) begin
                expValid = 1'b1;
                expDouta = rdQueue[0].data;
                expKnown = rdQueue[0].known;
                void'(rdQueue.pop_front());
            end
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("cmp_rd_valid", {31'b0, rdValid}, {31'b0, expValid});
            if (expKnown) checkOutput("cmp_douta", douta, expDouta);
            checkOutput("cmp_err_oob", {31'b0, errOob}, {31'b0, expOob});
`ifdef NN_RAM_STATS_EN
            checkOutput("cmp_rd_count", rdCount, expRd);
            checkOutput("cmp_wr_count", wrCount, expWr);
`else
            checkOutput("cmp_rd_count", rdCount, 32'h0);
            checkOutput("cmp_wr_count", wrCount, 32'h0);
`endif
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic        sampValid [12];
    logic [31:0] sampData  [12];

    initial begin
        rsta = 1'b1; ena = 1'b0; wea = 4'h0; addra = '0; dina = '0;
        @(negedge clk);

        // Reset state
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        modelReady = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h10, 32'h12345678);
        checkOutput("reset_douta", douta, 32'h0);
        checkOutput("reset_valid", {31'b0, rdValid}, 32'h0);
        checkOutput("reset_oob", {31'b0, errOob}, 32'h0);

        // Latency 3: write then read byte address 0x10
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        idleCycles(3);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
        checkOutput("lat_c1_valid", {31'b0, rdValid}, 32'h0);
        idleCycles(1);
        checkOutput("lat_c2_valid", {31'b0, rdValid}, 32'h0);
        idleCycles(1);
        checkOutput("lat_c3_valid", {31'b0, rdValid}, 32'h1);
        checkOutput("lat_c3_douta", douta, 32'hDEADBEEF);
        idleCycles(1);
        checkOutput("lat_c4_valid", {31'b0, rdValid}, 32'h0);
        checkOutput("lat_hold_douta", douta, 32'hDEADBEEF);

        // Byte enables on word 5
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h14, 32'h11223344);
        applyStimulus(1'b0, 1'b1, 4'h5, 32'h14, 32'hAABBCCDD);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h14, 32'h0);
        idleCycles(2);
        checkOutput("byte_en_douta", douta, 32'h11BB33DD);

        // Read-first on word 0
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h0, 32'h7);
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h0, 32'h1);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        idleCycles(1);
        checkOutput("rdfirst_old", douta, 32'h7);
        idleCycles(1);
        checkOutput("rdfirst_new", douta, 32'h1);

        // Streaming: fill words 0..7, then 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 4'hF, 32'(i * 4), 32'h1000_0000 + 32'(i));
        end
        idleCycles(3);
        for (int j = 0; j < 12; j++) begin
            if (j < 8) applyStimulus(1'b0, 1'b1, 4'h0, 32'(j * 4), 32'h0);
            else       idleCycles(1);
            sampValid[j] = rdValid;
            sampData[j]  = douta;
        end
        for (int j = 0; j < 12; j++) begin
            checkOutput($sformatf("stream_valid_%0d", j), {31'b0, sampValid[j]},
                        (j >= 2 && j <= 9) ? 32'h1 : 32'h0);
            if (j >= 2 && j <= 9) begin
                checkOutput($sformatf("stream_data_%0d", j), sampData[j], 32'h1000_0000 + 32'(j - 2));
            end
        end

        // Last in-range word and sub-word byte address
        applyStimulus(1'b0, 1'b1, 4'hF, 32'hFFC, 32'hCAFEF00D);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'hFFC, 32'h0);
        idleCycles(2);
        checkOutput("last_word", douta, 32'hCAFEF00D);
        checkOutput("last_word_oob", {31'b0, errOob}, 32'h0);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h13, 32'h0);
        idleCycles(2);
        checkOutput("unaligned_addr", douta, 32'h1000_0004);

        // Out of range: index 1024 must not wrap onto word 0
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF);
        checkOutput("oob_flag_set", {31'b0, errOob}, 32'h1);
        idleCycles(1);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h1000, 32'h0);
        idleCycles(2);
        checkOutput("oob_read_valid", {31'b0, rdValid}, 32'h1);
        checkOutput("oob_read_data", douta, 32'h0);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        idleCycles(2);
        checkOutput("oob_no_wrap", douta, 32'h1000_0000);
        checkOutput("oob_sticky", {31'b0, errOob}, 32'h1);

        // Reset one cycle after a read is launched
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h14, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("midrst_douta", douta, 32'h0);
        checkOutput("midrst_oob", {31'b0, errOob}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            idleCycles(1);
            checkOutput($sformatf("midrst_novalid_%0d", k), {31'b0, rdValid}, 32'h0);
        end

        // Statistics: 10 accepted cycles (4 writes) and 3 idle cycles; also checks retention
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h14, 32'h0);
        idleCycles(1);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
        checkOutput("retain_word5", douta, 32'h1000_0005);
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h190, 32'h0000_00A0);
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h194, 32'h0000_00A1);
        idleCycles(1);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h190, 32'h0);
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h198, 32'h0000_00A2);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'hFFC, 32'h0);
        applyStimulus(1'b0, 1'b1, 4'h6, 32'h190, 32'h00BB_CC00);
        idleCycles(1);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h194, 32'h0);
        applyStimulus(1'b0, 1'b1, 4'h0, 32'h190, 32'h0);
        idleCycles(2);
        checkOutput("partial_merge", douta, 32'h00BB_CCA0);
        idleCycles(1);
`ifdef NN_RAM_STATS_EN
        checkOutput("stats_rd_count", rdCount, 32'd10);
        checkOutput("stats_wr_count", wrCount, 32'd4);
`else
        checkOutput("stats_rd_count", rdCount, 32'd0);
        checkOutput("stats_wr_count", wrCount, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/nn_ram_model_p.md
Name: nn_ram_model_p

Overview:
Parametrised, behavioural single-port RAM model for the NN core simulation benches. It replaces the fixed data, weight and instruction RAM models with one block. Configurable data width, depth, byte/word addressing and read latency. Adds a read-valid strobe, out-of-range detection and optional access statistics. It sits between the core's *_addr/_din/_dout/_en/_we buses and the bench.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8 (16 for instruction memory, 32 for data/weight).
ADDR_W, 32, width of addra.
DEPTH, 1024, number of DATA_W-bit words.
READ_LATENCY, 1, cycles from an accepted ena to douta update; legal range 1..4.
BYTE_ADDR, 1, 1: addra is a byte address, so word index = addra >> log2(DATA_W/8); 0: addra is a word index.

Ports:
clka  in  1  clock; all logic on its rising edge
rsta  in  1  synchronous active-high reset
ena  in  1  port enable; a read (and optional write) is performed in any cycle with ena=1
wea  in  DATA_W/8  byte write enables, qualified by ena
addra  in  ADDR_W  address, interpreted according to BYTE_ADDR
dina  in  DATA_W  write data
douta  out  DATA_W  read data
rd_valid  out  1  one-cycle pulse when douta carries the result of a read
err_oob  out  1  sticky flag: an access hit a word index >= DEPTH
rd_count  out  32  number of accepted ena cycles (stats feature)
wr_count  out  32  number of accepted cycles with wea != 0 (stats feature)

Behaviour:
- Clock and reset: one clock, clka. rsta is synchronous and active-high.
- Reset values: douta=0, rd_valid=0, err_oob=0, rd_count=0, wr_count=0. The read pipeline is flushed.
- Memory contents are not cleared by rsta. Before any write, array contents are X.
- Reset priority: a cycle with rsta=1 ignores ena/wea entirely. No write is performed and no read is launched.
- Reset mid-operation: reads in flight are dropped; rd_valid stays 0 until a new read completes its full latency after rsta is released.
- Accepted cycle: rsta=0 and ena=1.
  - Index idx is computed from addra per BYTE_ADDR.
  - In BYTE_ADDR mode the low log2(DATA_W/8) address bits are ignored; there is no misalignment error.
- Write: for each byte b with wea[b]=1, mem[idx] byte b <= dina byte b. Other bytes are unchanged.
- Read-first ordering: a read in the same cycle as a write to the same idx returns the old contents.
- Read pipeline: a READ_LATENCY-deep shift register of {valid, data}.
  - An accepted cycle loads {1, mem[idx]}; any other cycle loads {0, hold}.
  - At the output, douta updates only when the stage valid=1; otherwise it holds its last value.
  - rd_valid equals the output-stage valid bit.
  - Back-to-back accepted cycles produce back-to-back rd_valid pulses with no bubbles: throughput is 1 read per cycle.
- Out of range (idx >= DEPTH):
  - The write is suppressed and the read returns 0 with rd_valid still pulsed.
  - err_oob is set 1 on the next edge and holds until rsta.
- ena=0: wea, addra and dina are don't-care; memory and counters are unchanged.
- Width rules: idx is truncated to ADDR_W bits before the range compare; no wrap-around modulo DEPTH.
- Parameter checks: an illegal READ_LATENCY or a DATA_W not divisible by 8 triggers $error at elaboration/time 0.

Optional Feature:
Macro NN_RAM_STATS_EN.
- Defined:
  - rd_count increments on every accepted cycle.
  - wr_count increments on every accepted cycle with wea != 0, including out-of-range attempts.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rsta.
- Not defined: rd_count and wr_count are constant 0 and no counter flops are built.

Test Plan:
- Reset/latency: READ_LATENCY=3, write 32'hDEADBEEF at byte addr 0x10, then read 0x10 → rd_valid pulses exactly 3 cycles after the read's ena and douta=32'hDEADBEEF. During rsta=1, douta=0 and rd_valid=0.
- Byte enables: write 32'h11223344 to word 5, then write wea=4'b0101 with dina=32'hAABBCCDD → read word 5 returns 32'h11BB33DD.
- Read-first and streaming: in the same cycle, write 32'h1 to addr 0 and read addr 0 (old value 32'h7) → douta=32'h7, and the next read gives 32'h1. Then issue 8 consecutive reads of words 0..7 → 8 consecutive rd_valid pulses, data in order.
- Out of range: DEPTH=1024, BYTE_ADDR=1, write to addra=0x1000 (idx 1024) → no memory change, read returns 0 with rd_valid=1, err_oob=1 until rsta.
- Reset mid-read: READ_LATENCY=4, launch reads, assert rsta one cycle later for 1 cycle → no rd_valid pulse afterwards, douta=0, and memory retains written values.
- Stats (NN_RAM_STATS_EN defined): 10 accepted cycles, 4 of them with wea != 0, plus 3 cycles with ena=0 → rd_count=10, wr_count=4. Without the macro, both read 0.
